// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector (Mealy) with overlap control and a saturating match counter.
// Build option: define DET_REG_EN to register det (one cycle later, glitch-free).
module seq_pattern_detector #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int                FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PAT_W - 1);

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  state_t             state, state_nxt;
  logic [FILL_W-1:0]  fill, fill_nxt;
  logic [PAT_W-2:0]   hist, hist_nxt;
  logic [PAT_W-1:0]   window;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               sat_nxt;
  logic               match;

  // State register; reset discards any partially received pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      fill      <= '0;
      hist      <= '0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill      <= fill_nxt;
      hist      <= hist_nxt;
      match_cnt <= cnt_nxt;
      cnt_sat   <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    hist_nxt  = hist;
    cnt_nxt   = match_cnt;
    sat_nxt   = cnt_sat;
    window    = {hist, in_bit};
    match     = in_valid && (state == RUN) && (window == PATTERN);

    if (in_valid) begin
      hist_nxt = window[PAT_W-2:0];
      case (state)
        FILL: begin
          fill_nxt = fill + 1'b1;
          if (fill_nxt == LAST_FILL) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          // Non-overlapping: the matched bits may not seed the next match.
          if (match && !overlap) begin
            fill_nxt  = '0;
            hist_nxt  = '0;
            state_nxt = FILL;
          end
        end
        default: state_nxt = FILL;
      endcase
    end

    if (cnt_clr) begin
      cnt_nxt = '0;
      sat_nxt = 1'b0;
    end else if (match) begin
      if (&match_cnt) begin
        sat_nxt = 1'b1;
      end else begin
        cnt_nxt = match_cnt + 1'b1;
      end
    end
  end

`ifdef DET_REG_EN
  logic det_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      det_r <= 1'b0;
    end else begin
      det_r <= match;
    end
  end

  assign det = det_r;
`else
  assign det = match;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: three instances (101/8-bit count, 101/2-bit count, A5/8-bit count)
// share one stimulus stream and are compared against a queue-based reference model.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       det_a, det_c, det_w;
  logic       sat_a, sat_c, sat_w;
  logic [7:0] cnt_a, cnt_w;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap),
    .cnt_clr(cnt_clr), .det(det_a), .match_cnt(cnt_a), .cnt_sat(sat_a));

  seq_pattern_detector #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap),
    .cnt_clr(cnt_clr), .det(det_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

  seq_pattern_detector #(.PAT_W(8), .PATTERN(8'hA5), .CNT_W(8)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap),
    .cnt_clr(cnt_clr), .det(det_w), .match_cnt(cnt_w), .cnt_sat(sat_w));

`ifdef DET_REG_EN
  localparam bit REG_MODE = 1'b1;
`else
  localparam bit REG_MODE = 1'b0;
`endif

  int          patw [3] = '{3, 3, 8};
  logic [31:0] patv [3] = '{32'h5, 32'h5, 32'hA5};
  int          cmax [3] = '{255, 3, 255};

  // Model: valid bits received since the last reset or non-overlapping match.
  bit          mq [3][$];
  int          mcnt [3];
  bit          msat [3];
  bit          mprev [3];
  bit          mmatch [3];

  logic        act_det [3];
  logic        exp_det [3];
  logic [31:0] act_cnt [3];
  logic        act_sat [3];

  int vectors = 0;
  int miscompares = 0;
  int beat = 0;
  int hits = 0;

  task automatic apply_beat(input logic r, input logic clr, input logic ov, input logic v, input logic b);
    int n;
    @(negedge clk);
    rst = r; cnt_clr = clr; overlap = ov; in_valid = v; in_bit = b;
    #2;
    for (int k = 0; k < 3; k++) begin
      n = mq[k].size();
      mmatch[k] = 1'b0;
      if (v && n >= patw[k] - 1) begin
        mmatch[k] = (b == patv[k][0]);
        for (int j = 0; j < patw[k] - 1; j++) begin
          if (mq[k][n - (patw[k] - 1) + j] != patv[k][patw[k] - 1 - j]) mmatch[k] = 1'b0;
        end
      end
      exp_det[k] = REG_MODE ? mprev[k] : mmatch[k];
    end
    act_det[0] = det_a; act_det[1] = det_c; act_det[2] = det_w;
    if (det_a === 1'b1) hits++;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        mq[k].delete();
        mcnt[k] = 0; msat[k] = 1'b0; mprev[k] = 1'b0;
      end else begin
        if (v) begin
          if (mmatch[k] && !ov) mq[k].delete();
          else begin
            mq[k].push_back(b);
            if (mq[k].size() > 40) void'(mq[k].pop_front());
          end
        end
        if (clr) begin
          mcnt[k] = 0; msat[k] = 1'b0;
        end else if (mmatch[k]) begin
          if (mcnt[k] == cmax[k]) msat[k] = 1'b1;
          else mcnt[k]++;
        end
        mprev[k] = mmatch[k];
      end
    end
    act_cnt[0] = {24'b0, cnt_a}; act_cnt[1] = {30'b0, cnt_c}; act_cnt[2] = {24'b0, cnt_w};
    act_sat[0] = sat_a; act_sat[1] = sat_c; act_sat[2] = sat_w;
    beat++;
  endtask

  task automatic test_reset();
    apply_beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (cnt_a !== 8'd0 || cnt_c !== 2'd0 || cnt_w !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_cnt: got %0h/%0h/%0h want 0/0/0", cnt_a, cnt_c, cnt_w);
    end
    vectors++;
    if ({sat_a, sat_c, sat_w} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_sat: got %b%b%b want 000", sat_a, sat_c, sat_w);
    end
    vectors++;
    if ({det_a, det_c, det_w} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_det: got %b%b%b want 000", det_a, det_c, det_w);
    end
  endtask

  // Each stimulus entry is {rst, cnt_clr, overlap, in_valid, in_bit}.
  task automatic test_directed(input string nm, input logic [4:0] s [16], input int len,
                               input int want_hits, input int want_cnt_a);
    for (int i = 0; i < len; i++) begin
      if (i == 1) hits = 0;
      apply_beat(s[i][4], s[i][3], s[i][2], s[i][1], s[i][0]);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (act_det[k] !== exp_det[k]) begin
          miscompares++;
          $display("[TB] FAIL %s det[%0d] beat %0d: got %b want %b", nm, k, i, act_det[k], exp_det[k]);
        end
        vectors++;
        if (act_cnt[k] !== 32'(mcnt[k]) || act_sat[k] !== msat[k]) begin
          miscompares++;
          $display("[TB] FAIL %s cnt[%0d] beat %0d: got %0d/%b want %0d/%b", nm, k, i,
                   act_cnt[k], act_sat[k], mcnt[k], msat[k]);
        end
      end
    end
    apply_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hits !== want_hits) begin
      miscompares++;
      $display("[TB] FAIL %s det_count: got %0d want %0d", nm, hits, want_hits);
    end
    vectors++;
    if (cnt_a !== 8'(want_cnt_a)) begin
      miscompares++;
      $display("[TB] FAIL %s match_cnt: got %0d want %0d", nm, cnt_a, want_cnt_a);
    end
  endtask

  task automatic test_saturation();
    logic [4:0] s [12];
    s[0] = 5'b10000;
    s[1] = 5'b00111;
    for (int i = 2; i < 12; i++) s[i] = (i % 2 == 0) ? 5'b00110 : 5'b00111;
    s[11] = 5'b01111;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) hits = 0;
      apply_beat(s[i][4], s[i][3], s[i][2], s[i][1], s[i][0]);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (act_det[k] !== exp_det[k] || act_cnt[k] !== 32'(mcnt[k]) || act_sat[k] !== msat[k]) begin
          miscompares++;
          $display("[TB] FAIL saturation inst %0d beat %0d: got %b/%0d/%b want %b/%0d/%b", k, i,
                   act_det[k], act_cnt[k], act_sat[k], exp_det[k], mcnt[k], msat[k]);
        end
      end
      if (i == 9) begin
        vectors++;
        if (cnt_c !== 2'd3 || sat_c !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL sat_after_4th: got %0d/%b want 3/1", cnt_c, sat_c);
        end
      end
    end
    vectors++;
    if (cnt_c !== 2'd0 || sat_c !== 1'b0 || cnt_a !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL clr_on_5th: got %0d/%b/%0d want 0/0/0", cnt_c, sat_c, cnt_a);
    end
    apply_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hits !== 5) begin
      miscompares++;
      $display("[TB] FAIL saturation det_count: got %0d want 5", hits);
    end
  endtask

  task automatic test_random();
    bit   pend [$];
    logic ov = 1'b1;
    logic r, clr, v, b;
    apply_beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if (pend.size() == 0 && $urandom_range(0, 4) == 0) begin
        for (int j = 7; j >= 0; j--) pend.push_back(8'hA5 >> j);
      end
      if ($urandom_range(0, 15) == 0) ov = ~ov;
      clr = ($urandom_range(0, 39) == 0);
      r   = ($urandom_range(0, 149) == 0);
      if (pend.size() != 0) begin
        v = 1'b1;
        b = pend.pop_front();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        b = 1'($urandom_range(0, 1));
      end
      apply_beat(r, clr, ov, v, b);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (act_det[k] !== exp_det[k]) begin
          miscompares++;
          $display("[TB] FAIL random det[%0d] beat %0d: got %b want %b", k, i, act_det[k], exp_det[k]);
        end
        vectors++;
        if (act_cnt[k] !== 32'(mcnt[k]) || act_sat[k] !== msat[k]) begin
          miscompares++;
          $display("[TB] FAIL random cnt[%0d] beat %0d: got %0d/%b want %0d/%b", k, i,
                   act_cnt[k], act_sat[k], mcnt[k], msat[k]);
        end
      end
    end
  endtask

  initial begin
    logic [4:0] s [16];
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0; msat[k] = 1'b0; mprev[k] = 1'b0; mmatch[k] = 1'b0;
    end
    test_reset();

    s = '{default: 5'b00000};
    s[0] = 5'b10000; s[1] = 5'b00111; s[2] = 5'b00110; s[3] = 5'b00111; s[4] = 5'b00110; s[5] = 5'b00111;
    test_directed("overlap", s, 6, 2, 2);

    s = '{default: 5'b00000};
    s[0] = 5'b10000; s[1] = 5'b00011; s[2] = 5'b00010; s[3] = 5'b00011; s[4] = 5'b00010;
    s[5] = 5'b00011; s[6] = 5'b00010; s[7] = 5'b00011;
    test_directed("non_overlap", s, 8, 2, 2);

    s = '{default: 5'b00000};
    s[0] = 5'b10000; s[1] = 5'b00111; s[2] = 5'b00110; s[3] = 5'b00101; s[4] = 5'b00100;
    s[5] = 5'b00101; s[6] = 5'b00111;
    test_directed("valid_gap", s, 7, 1, 1);

    test_saturation();

    s = '{default: 5'b00000};
    s[0] = 5'b10000; s[1] = 5'b00111; s[2] = 5'b00110; s[3] = 5'b10100; s[4] = 5'b00111;
    s[5] = 5'b00110; s[6] = 5'b00111;
    test_directed("reset_mid", s, 7, 1, 1);

    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
